logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit for the ALU datapath. It generalises the fixed 4-bit AND slice to a WIDTH-bit, eight-operation unit and adds an accumulator mode that chains results. It also reports zero, all-ones and parity flags. Operands enter through a valid/ready handshake and results leave through one, so the unit sits between the operand-select stage and the ALU result mux, with backpressure handled at full throughput.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit accepts beat this cycle
- op  in  3  operation select (sampled with the beat)
- acc_en  in  1  use accumulator instead of b as second operand
- acc_clr  in  1  clear accumulator to 0
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  logic result
- zero  out  1  result == 0
- ones  out  1  result == all ones
- parity  out  1  XOR-reduction of result (1 = odd count of ones)

## Operation
- Accept occurs when in_valid && in_ready.
- Second operand is op_b = acc_en ? acc : b.
- op encoding:
  - 000 AND a&op_b
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT a
  - 111 PASS a
- All ops are pure bitwise on WIDTH bits. No carries and no width growth.
- Stage 1 (S1): on accept, the computed result is registered into s1_res and s1_valid is set.
- Stage 2 (S2): s1_res is moved into the result register and the flags are computed from it and registered. out_valid is set.
- Accumulator acc (WIDTH bits, internal):
  - On accept, acc <= computed result (regardless of acc_en).
  - acc_clr without accept: acc <= 0.
  - acc_clr with accept: the accept wins. acc takes the new result. acc_clr in that cycle affects nothing else.
  - Back-to-back acc_en beats chain correctly with no bubble, because acc updates at accept time.
- Pipeline control:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_load (combinational, no dependence on in_valid)
  - s1_valid next = accept ? 1 : (s2_load ? 0 : s1_valid)
  - out_valid next = s2_load ? 1 : (out_ready ? 0 : out_valid)
- While out_valid && !out_ready, result and the flags hold stable. S1 holds. in_ready = 0 once S1 is full.
- Reset state:
  - s1_valid = 0, out_valid = 0
  - result = 0, zero = 1, ones = 0, parity = 0
  - acc = 0, s1_res = 0
  - in_ready = 1 during the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded with no output handshake. A beat offered in the reset cycle is not accepted, and acc is not updated.
- op values are all defined; no illegal state exists.

## Timing
- Latency: accept at edge N → result/flags valid after edge N+1 (out_valid visible in cycle N+1). That is 2 register stages.
- Throughput: 1 beat/cycle while out_ready = 1.
- Buffering capacity is 2 beats (S1 + S2). With out_ready held 0, a third beat is refused (in_ready = 0).
- Simultaneous out_ready and accept with both stages full: S2 drains, S1 advances and S1 reloads, all on the same edge. No beat is lost.
- Flags are always consistent with result in the same cycle.

## Test plan
- Reset then op=000, a=0xF0, b=0x3C, single beat → after 2 edges: result=0x30, zero=0, ones=0, parity=0. out_valid is a one-cycle pulse with out_ready=1.
- Sweep all 8 ops with a=0xA5, b=0x0F → results 05, AF, AA, FA, 50, 55, 5A, A5. Check parity per result (05→0, AF→0, AA→0, FA→0, 50→0, 55→0, 5A→0, A5→0) and the zero/ones flags. Add op=100 with a=b=0xFF → result 00, zero=1, and op=101 with a=b → result FF, ones=1.
- Accumulator chain, back-to-back: acc_clr, then a=0x01 OR acc_en, then a=0x02 OR acc_en, then a=0x80 OR acc_en → results 0x01, 0x03, 0x83 on consecutive cycles. acc_clr asserted together with a fourth accept (a=0x10, OR, acc_en) → result 0x93, and acc = 0x93 afterwards.
- Backpressure: out_ready=0 with 4 beats offered → exactly 2 accepted, in_ready low from the 3rd offer, result held stable. Then release out_ready → all 4 results emerge in order with no duplicates.
- Reset mid-stream: 2 beats in flight, then rst pulsed for 1 cycle → out_valid=0, result=0, zero=1, acc=0 after the reset edge. Next beat with acc_en, op=001, a=0x00 → result 0x00.
- WIDTH=1 and WIDTH=13 instantiations → random ops/operands compared against a bitwise model. Flags are correct at width extremes.

Source files
------------

// File: rtl/logic_unit_if.sv
// logic_unit_if: operand/result valid-ready bundle for logic_unit_pipe
interface logic_unit_if #(parameter int WIDTH = 8);
   logic in_valid, in_ready, acc_en, acc_clr, out_valid, out_ready, zero, ones, parity;
   logic [2:0] op;
   logic [WIDTH-1:0] a, b, result;
   modport master(output in_valid, op, acc_en, acc_clr, a, b, out_ready,
                  input in_ready, out_valid, result, zero, ones, parity);
   modport slave(input in_valid, op, acc_en, acc_clr, a, b, out_ready,
                 output in_ready, out_valid, result, zero, ones, parity);
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage WIDTH-bit bitwise logic unit with accumulator chaining and result flags
module logic_unit_pipe #(parameter int WIDTH = 8) (
   input logic clk,
   input logic rst,
   logic_unit_if.slave io
);
   logic [WIDTH-1:0] acc, s1_res, op_b, res, result;
   logic s1_valid, out_valid, zero, ones, parity, accept, s2_load;
   assign s2_load = s1_valid && (!out_valid || io.out_ready);
   assign io.in_ready = !s1_valid || s2_load;
   assign accept = io.in_valid && io.in_ready;
   assign io.out_valid = out_valid;
   assign io.result = result;
   assign io.zero = zero;
   assign io.ones = ones;
   assign io.parity = parity;
   always_comb begin
      op_b = io.acc_en ? acc : io.b;
      case (io.op)
         3'd0: res = io.a & op_b;
         3'd1: res = io.a | op_b;
         3'd2: res = io.a ^ op_b;
         3'd3: res = ~(io.a & op_b);
         3'd4: res = ~(io.a | op_b);
         3'd5: res = ~(io.a ^ op_b);
         3'd6: res = ~io.a;
         default: res = io.a;
      endcase
   end
   // acc follows every accepted result so chained beats need no bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         s1_res <= '0;
         s1_valid <= 1'b0;
         out_valid <= 1'b0;
         result <= '0;
         zero <= 1'b1;
         ones <= 1'b0;
         parity <= 1'b0;
      end else begin
         if (accept) begin
            s1_res <= res;
            acc <= res;
         end else if (io.acc_clr) acc <= '0;
         s1_valid <= accept ? 1'b1 : (s2_load ? 1'b0 : s1_valid);
         out_valid <= s2_load ? 1'b1 : (io.out_ready ? 1'b0 : out_valid);
         if (s2_load) begin
            result <= s1_res;
            zero <= ~|s1_res;
            ones <= &s1_res;
            parity <= ^s1_res;
         end
      end
   end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized checks of logic_unit_pipe at WIDTH 8, 1 and 13
module tb_logic_unit_pipe;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   logic in_valid = 0, acc_en = 0, acc_clr = 0, out_ready = 1;
   logic [2:0] op = 0;
   logic [12:0] a = 0, b = 0;
   int checks = 0, failures = 0;

   logic_unit_if #(8) i8();
   logic_unit_if #(1) i1();
   logic_unit_if #(13) i13();
   assign i8.in_valid = in_valid; assign i8.op = op; assign i8.acc_en = acc_en; assign i8.acc_clr = acc_clr;
   assign i8.a = a[7:0]; assign i8.b = b[7:0]; assign i8.out_ready = out_ready;
   assign i1.in_valid = in_valid; assign i1.op = op; assign i1.acc_en = acc_en; assign i1.acc_clr = acc_clr;
   assign i1.a = a[0:0]; assign i1.b = b[0:0]; assign i1.out_ready = out_ready;
   assign i13.in_valid = in_valid; assign i13.op = op; assign i13.acc_en = acc_en; assign i13.acc_clr = acc_clr;
   assign i13.a = a; assign i13.b = b; assign i13.out_ready = out_ready;

   logic_unit_pipe #(.WIDTH(8)) d8(.clk(clk), .rst(rst), .io(i8.slave));
   logic_unit_pipe #(.WIDTH(1)) d1(.clk(clk), .rst(rst), .io(i1.slave));
   logic_unit_pipe #(.WIDTH(13)) d13(.clk(clk), .rst(rst), .io(i13.slave));

   logic [12:0] res_o[3], acc_o[3];
   logic [2:0] vld_o, rdy_o, zero_o, ones_o, par_o;
   assign res_o[0] = 13'(i8.result); assign res_o[1] = 13'(i1.result); assign res_o[2] = i13.result;
   assign acc_o[0] = 13'(d8.acc); assign acc_o[1] = 13'(d1.acc); assign acc_o[2] = d13.acc;
   assign vld_o = {i13.out_valid, i1.out_valid, i8.out_valid};
   assign rdy_o = {i13.in_ready, i1.in_ready, i8.in_ready};
   assign zero_o = {i13.zero, i1.zero, i8.zero};
   assign ones_o = {i13.ones, i1.ones, i8.ones};
   assign par_o = {i13.parity, i1.parity, i8.parity};

   localparam int W[3] = '{8, 1, 13};
   function automatic logic [12:0] mask(input int k);
      return 13'((14'd1 << W[k]) - 14'd1);
   endfunction
   function automatic logic [12:0] f(input logic [2:0] o, input logic [12:0] x, y, m);
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return x ^ y;
         3'd3: return ~(x & y) & m;
         3'd4: return ~(x | y) & m;
         3'd5: return ~(x ^ y) & m;
         3'd6: return ~x & m;
         default: return x;
      endcase
   endfunction

   // reference model: FIFO of in-flight results, each tagged with the edge that accepted it
   typedef struct packed {logic [2:0][12:0] r; int t;} ent_t;
   ent_t q[$];
   logic [12:0] acc_m[3] = '{0, 0, 0}, last_r[3] = '{0, 0, 0};
   int cyc = 0;
   always @(negedge clk) begin
      bit ev, er;
      logic [12:0] d, m, y;
      ent_t e;
      ev = 0;
      if (q.size() > 0) ev = cyc > q[0].t;
      er = q.size() < 2 || out_ready;
      for (int k = 0; k < 3; k++) begin
         m = mask(k);
         d = ev ? q[0].r[k] : last_r[k];
         checks += 4;
         if (vld_o[k] !== ev) begin failures++; $display("FAIL mon_out_valid w=%0d got=%b want=%b t=%0t", W[k], vld_o[k], ev, $time); end
         if (rdy_o[k] !== er) begin failures++; $display("FAIL mon_in_ready w=%0d got=%b want=%b t=%0t", W[k], rdy_o[k], er, $time); end
         if (res_o[k] !== d || zero_o[k] !== (d == 0) || ones_o[k] !== (d == m) || par_o[k] !== ^d) begin
            failures++;
            $display("FAIL mon_result w=%0d got=%h z%b o%b p%b want=%h t=%0t", W[k], res_o[k], zero_o[k], ones_o[k], par_o[k], d, $time);
         end
         if (acc_o[k] !== acc_m[k]) begin failures++; $display("FAIL mon_acc w=%0d got=%h want=%h t=%0t", W[k], acc_o[k], acc_m[k], $time); end
      end
      if (rst) begin
         q.delete();
         acc_m = '{0, 0, 0};
         last_r = '{0, 0, 0};
      end else begin
         if (ev && out_ready) begin
            for (int k = 0; k < 3; k++) last_r[k] = q[0].r[k];
            void'(q.pop_front());
         end
         if (in_valid && er) begin
            for (int k = 0; k < 3; k++) begin
               m = mask(k);
               y = acc_en ? acc_m[k] : (b & m);
               e.r[k] = f(op, a & m, y, m);
               acc_m[k] = e.r[k];
            end
            e.t = cyc + 1;
            q.push_back(e);
         end else if (acc_clr) acc_m = '{0, 0, 0};
      end
      cyc++;
   end

   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (i8.out_valid !== 0 || i8.in_ready !== 1 || i8.result !== 8'h00 || i8.zero !== 1 || i8.ones !== 0 || i8.parity !== 0 || d8.acc !== 8'h00) begin
         failures++;
         $display("FAIL reset got v%b r%b res=%h z%b o%b p%b acc=%h want v0 r1 res=00 z1 o0 p0 acc=00",
                  i8.out_valid, i8.in_ready, i8.result, i8.zero, i8.ones, i8.parity, d8.acc);
      end
      @(posedge clk); #1 rst = 0;
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      out_ready = 1; op = 0; a = 13'h0F0; b = 13'h03C; acc_en = 0; acc_clr = 0; in_valid = 1;
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk);
      checks++;
      if (i8.out_valid !== 0) begin failures++; $display("FAIL single_early got out_valid=%b want 0", i8.out_valid); end
      @(negedge clk);
      checks++;
      if (i8.out_valid !== 1 || i8.result !== 8'h30 || i8.zero !== 0 || i8.ones !== 0 || i8.parity !== 0) begin
         failures++;
         $display("FAIL single got v%b res=%h z%b o%b p%b want v1 res=30 z0 o0 p0", i8.out_valid, i8.result, i8.zero, i8.ones, i8.parity);
      end
      @(negedge clk);
      checks++;
      if (i8.out_valid !== 0) begin failures++; $display("FAIL single_pulse got out_valid=%b want 0", i8.out_valid); end
   endtask

   task automatic test_ops();
      logic [2:0] xo[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 4, 5};
      logic [7:0] xa[10] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'h3C};
      logic [7:0] xb[10] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hFF, 8'h3C};
      logic [7:0] xr[10] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5, 8'h00, 8'hFF};
      int j = 0;
      @(posedge clk); #1;
      out_ready = 1; acc_en = 0; acc_clr = 0;
      for (int c = 0; c < 14; c++) begin
         in_valid = c < 10;
         if (c < 10) begin op = xo[c]; a = {5'b0, xa[c]}; b = {5'b0, xb[c]}; end
         @(negedge clk);
         if (i8.out_valid) begin
            checks++;
            if (j > 9) begin failures++; $display("FAIL ops_extra got res=%h want no beat", i8.result); end
            else if (i8.result !== xr[j] || i8.zero !== (j == 8) || i8.ones !== (j == 9) || i8.parity !== 0) begin
               failures++;
               $display("FAIL ops[%0d] got res=%h z%b o%b p%b want res=%h z%b o%b p0", j, i8.result, i8.zero, i8.ones, i8.parity, xr[j], j == 8, j == 9);
            end
            j++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (j != 10) begin failures++; $display("FAIL ops_count got %0d want 10", j); end
   endtask

   task automatic test_acc_chain();
      logic [7:0] xr[4] = '{8'h01, 8'h03, 8'h83, 8'h93};
      logic [7:0] xa[5] = '{8'h00, 8'h01, 8'h02, 8'h80, 8'h10};
      int j = 0, first = -1;
      @(posedge clk); #1;
      out_ready = 1; op = 1; acc_en = 1;
      for (int c = 0; c < 9; c++) begin
         in_valid = c >= 1 && c <= 4;
         acc_clr = c == 0 || c == 4;
         a = (c < 5) ? {5'b0, xa[c]} : 13'h0;
         b = 13'($urandom);
         @(negedge clk);
         if (i8.out_valid) begin
            if (first < 0) first = c;
            checks++;
            if (j > 3 || c != first + j || i8.result !== xr[j]) begin
               failures++;
               $display("FAIL acc_chain[%0d] got res=%h cyc=%0d want res=%h cyc=%0d", j, i8.result, c, (j < 4) ? xr[j] : 8'h00, first + j);
            end
            j++;
         end
         @(posedge clk); #1;
      end
      acc_clr = 0; acc_en = 0; in_valid = 0;
      @(negedge clk);
      checks++;
      if (j != 4 || d8.acc !== 8'h93) begin failures++; $display("FAIL acc_final got beats=%0d acc=%h want beats=4 acc=93", j, d8.acc); end
   endtask

   task automatic test_backpressure();
      logic [12:0] ba[4], bb[4], ex[4];
      logic [2:0] bo[4];
      int i = 0, j = 0;
      bit go;
      for (int n = 0; n < 4; n++) begin
         ba[n] = 13'($urandom); bb[n] = 13'($urandom); bo[n] = 3'($urandom);
         ex[n] = f(bo[n], ba[n] & 13'hFF, bb[n] & 13'hFF, 13'hFF);
      end
      @(posedge clk); #1;
      acc_en = 0; acc_clr = 0; out_ready = 0;
      for (int c = 0; c < 30 && j < 4; c++) begin
         if (c == 6) out_ready = 1;
         in_valid = i < 4;
         if (i < 4) begin op = bo[i]; a = ba[i]; b = bb[i]; end
         @(negedge clk);
         if (c == 2 || c == 5) begin
            checks++;
            if (i8.in_ready !== 0 || i8.out_valid !== 1 || i8.result !== ex[0][7:0] || i != 2) begin
               failures++;
               $display("FAIL bp_stall c=%0d got rdy%b v%b res=%h acc=%0d want rdy0 v1 res=%h acc=2", c, i8.in_ready, i8.out_valid, i8.result, i, ex[0][7:0]);
            end
         end
         if (out_ready && i8.out_valid) begin
            checks++;
            if (j > 3 || i8.result !== ex[j][7:0]) begin failures++; $display("FAIL bp_order[%0d] got res=%h want %h", j, i8.result, ex[j & 3][7:0]); end
            j++;
         end
         go = in_valid && i8.in_ready;
         @(posedge clk); #1;
         if (go) i++;
      end
      in_valid = 0;
      checks++;
      if (j != 4 || i != 4) begin failures++; $display("FAIL bp_count got out=%0d in=%0d want 4/4", j, i); end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (i8.out_valid !== 0) begin failures++; $display("FAIL bp_dup got out_valid=%b want 0", i8.out_valid); end
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      out_ready = 1; acc_en = 0; acc_clr = 0; in_valid = 1; op = 1; a = 13'h011; b = 13'h022;
      @(posedge clk); #1 a = 13'h044;
      @(posedge clk); #1 rst = 1; op = 7; a = 13'h055;
      @(posedge clk); #1 rst = 0; in_valid = 0;
      @(negedge clk);
      checks++;
      if (i8.out_valid !== 0 || i8.in_ready !== 1 || i8.result !== 8'h00 || i8.zero !== 1 || d8.acc !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid got v%b rdy%b res=%h z%b acc=%h want v0 rdy1 res=00 z1 acc=00", i8.out_valid, i8.in_ready, i8.result, i8.zero, d8.acc);
      end
      @(posedge clk); #1;
      in_valid = 1; acc_en = 1; op = 1; a = 13'h000; b = 13'h1FFF;
      @(posedge clk); #1 in_valid = 0; acc_en = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (i8.out_valid !== 1 || i8.result !== 8'h00 || i8.zero !== 1) begin
         failures++;
         $display("FAIL reset_mid_next got v%b res=%h z%b want v1 res=00 z1", i8.out_valid, i8.result, i8.zero);
      end
   endtask

   task automatic test_random();
      @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
         rst = $urandom_range(0, 249) == 0;
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         acc_en = $urandom_range(0, 1) == 1;
         acc_clr = $urandom_range(0, 7) == 0;
         op = 3'($urandom);
         a = 13'($urandom);
         b = $urandom_range(0, 7) == 0 ? 13'h1FFF : 13'($urandom);
         @(posedge clk); #1;
      end
      rst = 0; in_valid = 0; out_ready = 1; acc_clr = 0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_ops();
      test_acc_chain();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
